windowed_event_counter: RTL and testbench

Parametrised multi-channel event counter. Each channel keeps a free-running total and a windowed count over a programmable period. At every window boundary the windowed counts are snapshotted and streamed out one channel per beat over a valid/ready interface. It sits between the per-channel event strobes (singles, coincidences, timing errors) and the backend status/readout path. It supersedes the fixed DSP-macro event counter.

---
 rtl/windowed_event_counter.sv | 149 ++++++++++++++
 tb/tb_windowed_event_counter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/windowed_event_counter.sv
// Multi-channel event counter: free-running totals plus per-window snapshots streamed one channel per beat.
// Define EVENT_COUNTER_SATURATE_EN to make all counters saturate at 2^WIDTH-1 instead of wrapping.
module windowed_event_counter #(
  parameter  int NCOUNTERS    = 3,
  parameter  int WIDTH        = 48,
  parameter  int PERIOD_WIDTH = 32,
  localparam int CW           = (NCOUNTERS > 1) ? $clog2(NCOUNTERS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCOUNTERS-1:0]       signal,
  input  logic [NCOUNTERS-1:0]       load,
  input  logic [PERIOD_WIDTH-1:0]    period,
  output logic [NCOUNTERS*WIDTH-1:0] counters,
  output logic [WIDTH-1:0]           out_data,
  output logic [CW-1:0]              out_chan,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       overrun
);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  localparam logic [CW-1:0] LAST_CHAN = CW'(NCOUNTERS - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PERIOD_WIDTH-1:0] r_wcnt;
  logic [WIDTH-1:0]        r_total  [NCOUNTERS];
  logic [WIDTH-1:0]        r_wc     [NCOUNTERS];
  logic [WIDTH-1:0]        r_snap   [NCOUNTERS];
  logic [WIDTH-1:0]        w_wc_inc [NCOUNTERS];
  logic [CW-1:0]           r_chan;
  logic                    r_overrun;

  logic w_win_en;
  logic w_tick;
  logic w_streaming;
  logic w_fire;
  logic w_last_hs;
  logic w_capture;
  logic w_drop;

  function automatic logic [WIDTH-1:0] f_inc(input logic [WIDTH-1:0] v, input logic en);
`ifdef EVENT_COUNTER_SATURATE_EN
    f_inc = (en && (v != '1)) ? v + WIDTH'(1) : v;
`else
    f_inc = en ? v + WIDTH'(1) : v;
`endif
  endfunction

  // A period lowered below the current count still ticks, because the compare is >= not ==.
  assign w_win_en    = (period != '0);
  assign w_tick      = w_win_en && (r_wcnt >= period - PERIOD_WIDTH'(1));
  assign w_streaming = (r_state == S_STREAM);
  assign w_fire      = w_streaming && out_ready;
  assign w_last_hs   = w_fire && (r_chan == LAST_CHAN);
  assign w_capture   = w_tick && (!w_streaming || w_last_hs);
  assign w_drop      = w_tick && w_streaming && !w_last_hs;

  always_comb begin
    for (int i = 0; i < NCOUNTERS; i++) begin
      w_wc_inc[i] = f_inc(r_wc[i], signal[i]);
    end
  end

  for (genvar g = 0; g < NCOUNTERS; g++) begin : g_counters
    assign counters[g*WIDTH +: WIDTH] = r_total[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: the default assignment comes first so no branch can leave w_state_nxt unassigned and infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_tick) w_state_nxt = S_STREAM;
      S_STREAM: if (w_last_hs && !w_tick) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = w_streaming;
    out_chan  = r_chan;
    out_last  = w_streaming && (r_chan == LAST_CHAN);
    out_data  = w_streaming ? r_snap[r_chan] : '0;
    overrun   = r_overrun;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt    <= '0;
      r_chan    <= '0;
      r_overrun <= 1'b0;
      // NOTE: these arrays are plain flop banks, so they take the async reset like every other register.
      for (int i = 0; i < NCOUNTERS; i++) begin
        r_total[i] <= '0;
        r_wc[i]    <= '0;
        r_snap[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      r_overrun <= w_drop;

      if (!w_win_en || w_tick) begin
        r_wcnt <= '0;
      end else begin
        r_wcnt <= r_wcnt + PERIOD_WIDTH'(1);
      end

      for (int i = 0; i < NCOUNTERS; i++) begin
        if (load[i]) begin
          r_total[i] <= '0;
        end else begin
          r_total[i] <= f_inc(r_total[i], signal[i]);
        end

        // The tick-cycle event lands in the snapshot, not in the next window.
        if (!w_win_en || w_tick) begin
          r_wc[i] <= '0;
        end else begin
          r_wc[i] <= w_wc_inc[i];
        end

        if (w_capture) begin
          r_snap[i] <= w_wc_inc[i];
        end
      end

      if (w_capture || w_last_hs) begin
        r_chan <= '0;
      end else if (w_fire) begin
        r_chan <= r_chan + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_windowed_event_counter.sv
// Directed self-checking bench for windowed_event_counter (main instance N=3/WIDTH=48, plus a WIDTH=8 instance).
module tb_windowed_event_counter;

  localparam int N  = 3;
  localparam int W  = 48;
  localparam int PW = 32;

  typedef struct packed {
    logic         last;
    logic [1:0]   chan;
    logic [W-1:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    signal;
  logic [N-1:0]    load;
  logic [PW-1:0]   period;
  logic [N*W-1:0]  counters;
  logic [W-1:0]    out_data;
  logic [1:0]      out_chan;
  logic            out_valid;
  logic            out_last;
  logic            out_ready;
  logic            overrun;

  logic [N-1:0]    s8;
  logic [N*8-1:0]  counters8;
  logic [7:0]      out_data8;
  logic [1:0]      out_chan8;
  logic            out_valid8;
  logic            out_last8;
  logic            overrun8;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_ovr    = 0;
  logic   valid_seen = 1'b0;
  beat_t  q[$];
  logic [2:0] tbl [15];

  windowed_event_counter #(.NCOUNTERS(N), .WIDTH(W), .PERIOD_WIDTH(PW)) u_dut (
    .clk(clk), .rst(rst), .signal(signal), .load(load), .period(period),
    .counters(counters), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready), .overrun(overrun)
  );

  windowed_event_counter #(.NCOUNTERS(N), .WIDTH(8), .PERIOD_WIDTH(PW)) u_dut8 (
    .clk(clk), .rst(rst), .signal(s8), .load(3'b000), .period(32'd0),
    .counters(counters8), .out_data(out_data8), .out_chan(out_chan8),
    .out_valid(out_valid8), .out_last(out_last8), .out_ready(1'b1), .overrun(overrun8)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid && out_ready) q.push_back({out_last, out_chan, out_data});
    if (overrun) n_ovr++;
    if (out_valid) valid_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [2:0] sig);
    signal = sig;
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int base,
                             input logic [W-1:0] d0, input logic [W-1:0] d1, input logic [W-1:0] d2);
    logic [W-1:0] d [3];
    beat_t b;
    d[0] = d0; d[1] = d1; d[2] = d2;
    for (int i = 0; i < 3; i++) begin
      b = (base + i < q.size()) ? q[base + i] : '1;
      check($sformatf("%s_b%0d_chan", tag, i), 64'(b.chan), 64'(i));
      check($sformatf("%s_b%0d_data", tag, i), 64'(b.data), 64'(d[i]));
      check($sformatf("%s_b%0d_last", tag, i), 64'(b.last), 64'(i == 2));
    end
  endtask

  initial begin
    rst = 1'b1; signal = '0; load = '0; period = '0; out_ready = 1'b1; s8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_counters", 64'(counters == '0), 64'd1);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_chan", 64'(out_chan), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    rst = 1'b0;

    // Count and load with windowing disabled
    valid_seen = 1'b0;
    repeat (10) cyc(3'b010);
    check("t1_ch1_ten", 64'(counters[W +: W]), 64'd10);
    load = 3'b010;
    cyc(3'b010);
    load = 3'b000;
    check("t1_ch1_load", 64'(counters[W +: W]), 64'd0);
    check("t1_ch0", 64'(counters[0 +: W]), 64'd0);
    check("t1_ch2", 64'(counters[2*W +: W]), 64'd0);
    repeat (3) cyc(3'b000);
    check("t1_no_valid", 64'(valid_seen), 64'd0);

    // Window snapshot, period 16: ch0 every cycle, ch2 every 4th
    q.delete(); n_ovr = 0; period = 32'd16;
    for (int k = 0; k < 48; k++) begin
      cyc({(k % 4 == 0), 1'b0, 1'b1});
      if (k == 14) check("t2_valid_before_tick", 64'(out_valid), 64'd0);
      if (k == 15) begin
        check("t2_valid_rise", 64'(out_valid), 64'd1);
        check("t2_first_data", 64'(out_data), 64'd16);
      end
    end
    period = '0;
    repeat (5) cyc(3'b000);
    check("t2_nbeats", 64'(q.size()), 64'd9);
    check_frame("t2_f0", 0, 16, 0, 4);
    check_frame("t2_f1", 3, 16, 0, 4);
    check_frame("t2_f2", 6, 16, 0, 4);
    check("t2_overrun", 64'(n_ovr), 64'd0);

    // Backpressure: beat 0 held for 5 cycles
    q.delete(); n_ovr = 0; period = 32'd16;
    for (int k = 0; k < 16; k++) cyc({1'b0, 1'b1, (k % 2 == 0)});
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(3'b000);
      check($sformatf("t3_hold%0d_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("t3_hold%0d_chan", k), 64'(out_chan), 64'd0);
      check($sformatf("t3_hold%0d_data", k), 64'(out_data), 64'd8);
    end
    out_ready = 1'b1;
    repeat (3) cyc(3'b000);
    period = '0;
    repeat (3) cyc(3'b000);
    check("t3_nbeats", 64'(q.size()), 64'd3);
    check_frame("t3_f0", 0, 8, 16, 0);
    check("t3_overrun", 64'(n_ovr), 64'd0);

    // Back-to-back frames at period 3 with out_ready high
    q.delete(); n_ovr = 0; period = 32'd3;
    for (int k = 0; k < 12; k++) begin
      cyc(3'b101);
      if (k == 4) begin
        check("t4a_last_chan", 64'(out_chan), 64'd2);
        check("t4a_last_flag", 64'(out_last), 64'd1);
      end
      if (k == 5) begin
        check("t4a_restart_valid", 64'(out_valid), 64'd1);
        check("t4a_restart_chan", 64'(out_chan), 64'd0);
        check("t4a_restart_data", 64'(out_data), 64'd3);
      end
    end
    period = '0;
    repeat (5) cyc(3'b000);
    check("t4a_nbeats", 64'(q.size()), 64'd12);
    for (int f = 0; f < 4; f++) check_frame($sformatf("t4a_f%0d", f), 3 * f, 3, 0, 3);
    check("t4a_overrun", 64'(n_ovr), 64'd0);

    // Overrun with out_ready toggling: windows 2 and 4 are dropped
    tbl = '{3'b001, 3'b000, 3'b000, 3'b011, 3'b011, 3'b011, 3'b001, 3'b011,
            3'b000, 3'b011, 3'b011, 3'b011, 3'b010, 3'b110, 3'b010};
    q.delete(); n_ovr = 0; period = 32'd3;
    for (int e = 1; e <= 15; e++) begin
      out_ready = (e % 2 == 0);
      cyc(tbl[e-1]);
    end
    period = '0;
    for (int e = 16; e <= 25; e++) begin
      out_ready = (e % 2 == 0);
      cyc(3'b000);
    end
    out_ready = 1'b1;
    check("t4b_nbeats", 64'(q.size()), 64'd9);
    check_frame("t4b_w1", 0, 1, 0, 0);
    check_frame("t4b_w3", 3, 2, 1, 0);
    check_frame("t4b_w5", 6, 0, 3, 1);
    check("t4b_overrun", 64'(n_ovr), 64'd2);

    // Width boundary on the 8-bit instance
    s8 = 3'b001;
    repeat (300) cyc(3'b000);
    s8 = 3'b000;
`ifdef EVENT_COUNTER_SATURATE_EN
    check("t5_ch0_8bit", 64'(counters8[7:0]), 64'd255);
`else
    check("t5_ch0_8bit", 64'(counters8[7:0]), 64'd44);
`endif
    check("t5_ch1_8bit", 64'(counters8[15:8]), 64'd0);

    // Reset during beat 1
    period = 32'd4;
    repeat (5) cyc(3'b100);
    check("t6_pre_chan", 64'(out_chan), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_chan", 64'(out_chan), 64'd0);
    check("t6_rst_data", 64'(out_data), 64'd0);
    check("t6_rst_last", 64'(out_last), 64'd0);
    check("t6_rst_counters", 64'(counters == '0), 64'd1);
    repeat (2) cyc(3'b100);
    check("t6_held_counters", 64'(counters == '0), 64'd1);
    q.delete(); n_ovr = 0;
    rst = 1'b0;
    repeat (3) cyc(3'b100);
    check("t6_no_early_valid", 64'(out_valid), 64'd0);
    cyc(3'b100);
    check("t6_first_valid", 64'(out_valid), 64'd1);
    check("t6_ch2_total", 64'(counters[2*W +: W]), 64'd4);
    period = '0;
    repeat (4) cyc(3'b000);
    check("t6_nbeats", 64'(q.size()), 64'd3);
    check_frame("t6_f0", 0, 0, 0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
